// File: rtl/bridge_pkg.sv
// Shared types and AHB constants for the AHB-Lite to APB bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Largest legal Hsize (log2 of bytes per beat) for a 32- or 64-bit bus.
  function automatic logic [2:0] max_hsize(input int unsigned width);
    return (width == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// Address decoder: maps an AHB address onto a one-hot APB slave select,
// flagging addresses outside the bridge's window.
module ahb_apb_decoder
  import bridge_pkg::*;
#(
  parameter int unsigned           WIDTH       = 32,
  parameter int unsigned           SLAVES      = 4,
  parameter int unsigned           REGION_BITS = 12,
  parameter logic [WIDTH-1:0]      BASE_ADDR   = WIDTH'(32'h8000_0000)
) (
  input  logic [WIDTH-1:0]  Haddr,
  output logic [SLAVES-1:0] sel,
  output logic              miss
);

  localparam int unsigned SB = $clog2(SLAVES);
  localparam int unsigned HI = REGION_BITS + SB;

  logic [SB-1:0] idx;
  logic          unused_lo;

  assign idx       = Haddr[REGION_BITS +: SB];
  assign miss      = (Haddr[WIDTH-1:HI] != BASE_ADDR[WIDTH-1:HI]);
  assign sel       = miss ? '0 : (SLAVES'(1) << idx);
  assign unused_lo = ^Haddr[REGION_BITS-1:0];

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge; every output is registered.
// Define BRIDGE_APB3_EN to add the Pready/Pslverr handshake.
module ahb2apb_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SLAVES      = 4,
  parameter int unsigned      REGION_BITS = 12,
  parameter logic [WIDTH-1:0] BASE_ADDR   = WIDTH'(32'h8000_0000)
) (
  input  logic              clock,
  input  logic              Hresetn,
  input  logic [1:0]        Htrans,
  input  logic [2:0]        Hsize,
  input  logic [2:0]        Hburst,
  input  logic              Hwrite,
  input  logic [WIDTH-1:0]  Haddr,
  input  logic              Hreadyin,
  input  logic [WIDTH-1:0]  Hwdata,
  output logic [WIDTH-1:0]  Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout,
  output logic [SLAVES-1:0] Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [WIDTH-1:0]  Paddr,
  output logic [WIDTH-1:0]  Pwdata,
  input  logic [WIDTH-1:0]  Prdata
`ifdef BRIDGE_APB3_EN
  ,
  input  logic              Pready,
  input  logic              Pslverr
`endif
);

  bridge_state_e     state_q, state_d;
  logic [WIDTH-1:0]  haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [SLAVES-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]  hrdata_q, hrdata_d;
  logic [1:0]        hresp_q, hresp_d;
  logic              hreadyout_q, hreadyout_d;
  logic [SLAVES-1:0] pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [WIDTH-1:0]  paddr_q, paddr_d;
  logic [WIDTH-1:0]  pwdata_q, pwdata_d;

  logic [SLAVES-1:0] dec_sel;
  logic              dec_miss;
  logic              accept, bad_xfer;
  logic              pready, pslverr;
  logic              unused_ahb;

`ifdef BRIDGE_APB3_EN
  assign pready  = Pready;
  assign pslverr = Pslverr;
`else
  assign pready  = 1'b1;
  assign pslverr = 1'b0;
`endif

  ahb_apb_decoder #(
    .WIDTH       (WIDTH),
    .SLAVES      (SLAVES),
    .REGION_BITS (REGION_BITS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_decoder (
    .Haddr (Haddr),
    .sel   (dec_sel),
    .miss  (dec_miss)
  );

  // Htrans[1] alone separates NONSEQ/SEQ from IDLE/BUSY; burst type is irrelevant.
  assign accept     = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) && Hreadyin && Htrans[1];
  assign bad_xfer   = dec_miss || (Hsize > max_hsize(WIDTH));
  assign unused_ahb = ^{Hburst, Htrans[0]};

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    sel_d       = sel_q;
    hrdata_d    = hrdata_q;
    hresp_d     = hresp_q;
    hreadyout_d = hreadyout_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          haddr_d     = Haddr;
          hwrite_d    = Hwrite;
          sel_d       = dec_sel;
          hreadyout_d = 1'b0;
          hresp_d     = HRESP_OKAY;
          if (bad_xfer) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end else if (Hwrite) begin
            state_d = ST_WWAIT;
          end else begin
            // Reads skip WWAIT, so SETUP outputs are loaded straight from the bus.
            state_d  = ST_SETUP;
            pselx_d  = dec_sel;
            paddr_d  = Haddr;
            pwrite_d = 1'b0;
          end
        end else begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
        end
      end
      ST_WWAIT: begin
        state_d  = ST_SETUP;
        pwdata_d = Hwdata;
        pselx_d  = sel_q;
        paddr_d  = haddr_q;
        pwrite_d = hwrite_q;
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          pselx_d   = '0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          if (pslverr) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end else begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            if (!hwrite_q) hrdata_d = Prdata;
          end
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      sel_q       <= '0;
      hrdata_q    <= '0;
      hresp_q     <= HRESP_OKAY;
      hreadyout_q <= 1'b1;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      sel_q       <= sel_d;
      hrdata_q    <= hrdata_d;
      hresp_q     <= hresp_d;
      hreadyout_q <= hreadyout_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign Hrdata    = hrdata_q;
  assign Hresp     = hresp_q;
  assign Hreadyout = hreadyout_q;
  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

- Parametrised AHB-Lite slave to APB master bridge, the RTL core driven through `bridge_if`.
- Accepts single AHB transfers and decodes them onto one of `SLAVES` APB slaves. Each beat of a burst is handled as a single transfer.
- Inserts AHB wait states while the APB setup/access sequence runs.
- Reports decode misses, illegal sizes and (optionally) APB slave errors as a two-cycle AHB ERROR response.

## Interface
Parameters:
- `WIDTH`, 32: address and data width; must be 32 or 64.
- `SLAVES`, 4: number of APB slaves; a power of 2, at least 2.
- `REGION_BITS`, 12: log2 of the byte size of each slave window.
- `BASE_ADDR`, 32'h8000_0000: base of the slave windows; must be aligned to `SLAVES << REGION_BITS`.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `Hresetn` in 1: asynchronous, active-low reset.
- `Htrans` in 2, `Hsize` in 3, `Hburst` in 3, `Hwrite` in 1, `Haddr` in WIDTH: AHB address phase.
- `Hreadyin` in 1: high when the previous transfer has completed on the bus.
- `Hwdata` in WIDTH: AHB write data, valid in the data phase.
- `Hrdata` out WIDTH, `Hresp` out 2, `Hreadyout` out 1: AHB response.
- `Pselx` out SLAVES: one-hot APB select.
- `Penable` out 1, `Pwrite` out 1, `Paddr` out WIDTH, `Pwdata` out WIDTH: APB request.
- `Prdata` in WIDTH: APB read data.
- `Pready` in 1, `Pslverr` in 1: APB3 handshake; present only with `BRIDGE_APB3_EN`.

## Operation
- **FSM states:** IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- **Reset values:** every output is 0, except `Hreadyout` which is 1. State is IDLE.
- **Acceptance:** a transfer is accepted on an edge where all of these hold: state is IDLE or ERR2, `Hreadyin`=1, and `Htrans` is NONSEQ (2'b10) or SEQ (2'b11).
- **Register capture:** on acceptance, `Haddr` and `Hwrite` are registered.
- **Decode:**
  - Hit when `Haddr[WIDTH-1:REGION_BITS+log2(SLAVES)]` equals the same bits of `BASE_ADDR`.
  - The slave index is `Haddr[REGION_BITS +: log2(SLAVES)]`.
- **Error path:** a decode miss, or `Hsize` greater than log2(WIDTH/8), goes to ERR1. No APB activity occurs.
- **Read path:** IDLE → SETUP → ACCESS.
- **Write path:** IDLE → WWAIT → SETUP → ACCESS. `Hwdata` is captured into `Pwdata` at the WWAIT→SETUP edge.
- **SETUP:**
  - `Pselx[k]`=1, `Penable`=0.
  - `Paddr` = registered `Haddr`; `Pwrite` = registered `Hwrite`.
- **ACCESS:**
  - `Pselx[k]`=1, `Penable`=1.
  - The state is held while `Pready`=0.
  - On `Pready`=1 with `Pslverr`=0: go to IDLE, `Hrdata`←`Prdata` (reads only), `Hresp`=OKAY.
  - On `Pready`=1 with `Pslverr`=1: go to ERR1, and leave `Hrdata` unchanged.
- **ERR1:** `Hreadyout`=0, `Hresp`=ERROR (2'b01). Always goes to ERR2.
- **ERR2:** `Hreadyout`=1, `Hresp`=ERROR. Accepts a new transfer as IDLE does; otherwise goes to IDLE.
- **Non-transfers:** `Htrans` IDLE or BUSY in IDLE produces OKAY, zero wait, no state change.
- **Outside IDLE:** `Htrans` is ignored, because `Hreadyout`=0 stalls the master.
- **Between transfers:** `Pselx`, `Penable` and `Pwrite` return to 0. `Paddr` and `Pwdata` hold their last values.

## Timing
- **Registered outputs:** every output is registered; none is combinationally derived from an input.
- **Read:**
  - Address phase at edge T0.
  - SETUP in cycle T0+1, ACCESS in T0+2.
  - With `Pready`=1, `Hreadyout`=1 and `Hrdata` are valid in T0+3, which is 2 wait states.
- **Write:** WWAIT in T0+1, SETUP in T0+2, ACCESS in T0+3, `Hreadyout`=1 in T0+4, which is 3 wait states.
- **APB wait states:** each `Pready`=0 cycle adds one wait state.
- **Error:** ERR1 in T0+1, ERR2 in T0+2.
- **Back-to-back transfers:** the completion cycle (IDLE or ERR2 with `Hreadyout`=1) is also the address phase of the next transfer. There is no bubble.
- **Reset mid-transfer:** asserting `Hresetn` forces all outputs to their reset values immediately, asynchronously. The FSM goes to IDLE with no APB completion.

## Configuration
- **`BRIDGE_APB3_EN` defined:**
  - The `Pready` and `Pslverr` ports exist.
  - ACCESS stretches on `Pready`=0.
  - `Pslverr`=1 produces an AHB ERROR.
- **`BRIDGE_APB3_EN` undefined:**
  - No `Pready`/`Pslverr` ports.
  - ACCESS always lasts exactly one cycle.
  - APB slave errors are impossible; only decode and size errors give ERROR.

## Structure
- **Package `bridge_pkg`:**
  - State enum `bridge_state_e`.
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ.
  - HRESP constants OKAY=2'b00, ERROR=2'b01.
  - Function returning the maximum legal `Hsize` for a given `WIDTH`.
- **Sub-module `ahb_apb_decoder`:** combinational. Takes `Haddr` and produces the one-hot select plus a `miss` flag, using `SLAVES`, `REGION_BITS` and `BASE_ADDR`.

## Test plan
All scenarios use default parameters.

- Read `Haddr`=32'h8000_1004 with `Prdata`=32'hDEAD_BEEF and `Pready`=1 → `Pselx`=4'b0010 and `Paddr`=32'h8000_1004. `Hreadyout` is low for 2 cycles, then `Hrdata`=32'hDEAD_BEEF with OKAY.
- Write `Haddr`=32'h8000_3000 with `Hwdata`=32'h1234_5678 → `Pselx`=4'b1000, `Pwrite`=1, `Pwdata`=32'h1234_5678. Completes with 3 wait states, OKAY.
- Read `Haddr`=32'h9000_0000 → no `Pselx` activity. `Hreadyout` is 0 then 1, with `Hresp`=ERROR for both cycles.
- With `BRIDGE_APB3_EN`, `Pready` held low for 3 ACCESS cycles then `Pslverr`=1 → 5 wait states total, then the two-cycle ERROR response.
- Four-beat INCR write burst to 32'h8000_0000 → four complete SETUP/ACCESS pairs, `Paddr` stepping by 4, no idle cycle between beats.
- `Hresetn` pulsed low during ACCESS → `Pselx`=0, `Penable`=0 and `Hreadyout`=1 immediately. The next read after reset completes normally.
